sram_wr_ctl: RTL and testbench
==============================

# sram_wr_ctl

SRAM write controller sitting directly downstream of `datasg`. It accepts write requests (`request`, `wr_priority`, `des_port`, `address_write`, `data_write`) into a small FIFO and drives `busy`/`transfering` back to `datasg`. It drains the FIFO into the SRAM write port one word at a time. After each completed write it emits a one-cycle completion pulse tagged with port and priority for the queue manager.

## Interface
- `DATA_WIDTH`, 64, SRAM word / `data_write` width
- `ADDR_WIDTH`, 12, SRAM address width
- `DES_WIDTH`, 4, destination-port field width
- `PRI_WIDTH`, 3, priority field width
- `FIFO_DEPTH`, 4, request FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `request`  in  1  write request from `datasg`
- `wr_priority`  in  PRI_WIDTH  request priority
- `des_port`  in  DES_WIDTH  request destination port
- `address_write`  in  ADDR_WIDTH  SRAM address
- `data_write`  in  DATA_WIDTH  SRAM data
- `busy`  out  1  FIFO cannot accept; `datasg` holds its request
- `transfering`  out  1  write engine active (FSM ≠ IDLE)
- `sram_ready`  in  1  SRAM write port available this cycle
- `sram_we`  out  1  SRAM write strobe
- `sram_addr`  out  ADDR_WIDTH  SRAM write address
- `sram_wdata`  out  DATA_WIDTH  SRAM write data
- `wr_done`  out  1  completion pulse
- `done_port`  out  DES_WIDTH  port of the completed write
- `done_priority`  out  PRI_WIDTH  priority of the completed write
- `wr_count`  out  16  completed-write counter

## Operation
- Push: at a rising edge with `request`=1 and `busy`=0, {priority, port, addr, data} is written at the FIFO tail. A request seen while `busy`=1 is ignored; upstream holds it.
- `busy` is registered: 1 after any edge where the resulting occupancy is ≥ FIFO_DEPTH−1. A push accepted on the edge where `busy` rises therefore never overflows.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Empty when the pointers are equal; full when the MSBs differ and the rest match.
- FSM states:
  - IDLE → ISSUE when the FIFO is non-empty and `sram_ready`=1. The head is popped and `sram_we/addr/wdata` are registered.
  - ISSUE → DONE unconditionally. `sram_we` is cleared, `wr_done` is set, `done_*` show the issued entry, and `wr_count` increments (wraps 0xFFFF→0).
  - DONE → ISSUE if non-empty and `sram_ready`=1 (pop as above), otherwise → IDLE.
- Non-empty but `sram_ready`=0: stay in IDLE or DONE→IDLE. The FIFO retains its entries.
- Simultaneous push and pop: occupancy unchanged. Pushing into an empty FIFO makes the entry poppable on the next edge; there is no bypass.
- Reset value of every output is 0: `busy`, `transfering`, `sram_we`, `sram_addr`, `sram_wdata`, `wr_done`, `done_*`, `wr_count`, including the `sram_wpar` output described under Configuration. FIFO is emptied, FSM → IDLE.
- Reset asserted mid-write aborts the in-flight write. No `wr_done` is produced for it, and all queued entries are discarded.

## Timing
- Request accepted at edge N into an empty FIFO with `sram_ready`=1: `sram_we`=1 in cycle N+1..N+2 (after edge N+1). `wr_done`=1 for the following cycle (after edge N+2).
- Throughput: one write per 2 cycles. `sram_we` and `wr_done` are each exactly one cycle wide, and never high together.
- `transfering` is registered and high exactly while FSM ∈ {ISSUE, DONE}.
- `sram_addr`/`sram_wdata` hold their last value after ISSUE. They are only meaningful while `sram_we`=1.

## Configuration
- `SRAM_WR_PARITY_EN` defined:
  - Adds output `sram_wpar` [DATA_WIDTH/8−1:0], even parity per data byte.
  - Registered alongside `sram_wdata`, valid with `sram_we`.
- Not defined: the port and parity logic are absent, and behaviour is otherwise identical.

## Structure
- Shared package `sram_ctl_pkg`:
  - Width constants: DATA/ADDR/DES/PRI.
  - FSM state encoding: IDLE=0, ISSUE=1, DONE=2.
  - Request entry struct.
- Sub-module `sram_wr_fifo` holds storage, pointers, occupancy and `busy`. The FSM, SRAM outputs, counter and parity stay in `sram_wr_ctl`.

## Test plan
- Reset: pulse `rst` low at t=2 with garbage inputs → all outputs 0, FSM IDLE, `busy`=0.
- Single write: request addr 0x123, data 0xDEAD_BEEF_0000_0001, port 5, prio 3, `sram_ready`=1 → `sram_we` with those values 2 edges later. Then `wr_done` with port 5 / prio 3, and `wr_count`=1.
- Back-pressure: `sram_ready`=0, 4 consecutive requests → `busy` rises after the 3rd push and the 4th is held, so no overflow. Release `sram_ready` → 4 writes in FIFO order at 2-cycle spacing.
- Stall mid-stream: deassert `sram_ready` during DONE → FSM returns to IDLE with entries retained, and writes resume when ready=1.
- Counter wrap: preload 0xFFFF completions, then one more write → `wr_count`=0.
- Reset mid-write: assert `rst` during ISSUE with 2 entries queued → no `wr_done`, FIFO empty, no further `sram_we`. With `SRAM_WR_PARITY_EN`, data 0x01 → `sram_wpar`[0]=1, other bits 0.

Source files
------------

// File: rtl/sram_ctl_pkg.sv
// Shared types for the SRAM write controller: default widths, FSM encoding and
// the request entry layout used at the default widths.
package sram_ctl_pkg;

  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DES_W  = 4;
  localparam int SRAM_PRI_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [SRAM_PRI_W-1:0]  pri;
    logic [SRAM_DES_W-1:0]  port;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/sram_wr_fifo.sv
// Request FIFO: storage, wrapping pointers and the registered busy flag that
// stops upstream one entry before the FIFO fills.
module sram_wr_fifo #(
  parameter int WIDTH = 83,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_d;
  logic             busy_q, busy_d;
  logic             full, push_ok, pop_ok;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign busy    = busy_q;

  // busy reflects the occupancy this edge leaves behind, so a push accepted on
  // the edge that raises it still has a free slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    count_d  = wr_ptr_d - rd_ptr_d;
    busy_d   = (count_d >= (AW+1)'(DEPTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sram_wr_ctl.sv
// SRAM write controller: queues datasg requests and writes them one word per
// two cycles. Optional byte parity output is enabled by SRAM_WR_PARITY_EN.
module sram_wr_ctl
  import sram_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DES_WIDTH  = SRAM_DES_W,
  parameter int PRI_WIDTH  = SRAM_PRI_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic [PRI_WIDTH-1:0]  wr_priority,
  input  logic [DES_WIDTH-1:0]  des_port,
  input  logic [ADDR_WIDTH-1:0] address_write,
  input  logic [DATA_WIDTH-1:0] data_write,
  output logic                  busy,
  output logic                  transfering,
  input  logic                  sram_ready,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
`ifdef SRAM_WR_PARITY_EN
  output logic [DATA_WIDTH/8-1:0] sram_wpar,
`endif
  output logic                  wr_done,
  output logic [DES_WIDTH-1:0]  done_port,
  output logic [PRI_WIDTH-1:0]  done_priority,
  output logic [15:0]           wr_count,
  output wr_state_e             dbg_state
);

  localparam int ENTRY_W = PRI_WIDTH + DES_WIDTH + ADDR_WIDTH + DATA_WIDTH;

  // Handshake: a request is taken on any rising edge where request=1 and
  // busy=0; while busy=1 upstream must hold request and its fields stable.
  logic                  push, pop, fifo_empty;
  logic [ENTRY_W-1:0]    head;
  logic [PRI_WIDTH-1:0]  head_pri;
  logic [DES_WIDTH-1:0]  head_port;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  wr_state_e             state_q, state_d;
  logic                  sram_we_q, sram_we_d;
  logic                  wr_done_q, wr_done_d;
  logic                  transfering_q, transfering_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DES_WIDTH-1:0]  iss_port_q, iss_port_d, done_port_q, done_port_d;
  logic [PRI_WIDTH-1:0]  iss_pri_q, iss_pri_d, done_pri_q, done_pri_d;
  logic [15:0]           wr_count_q, wr_count_d;

  assign push = request && !busy;
  assign {head_pri, head_port, head_addr, head_data} = head;

  sram_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data ({wr_priority, des_port, address_write, data_write}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .busy      (busy)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    sram_we_d   = 1'b0;
    wr_done_d   = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    iss_port_d  = iss_port_q;
    iss_pri_d   = iss_pri_q;
    done_port_d = done_port_q;
    done_pri_d  = done_pri_q;
    wr_count_d  = wr_count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!fifo_empty && sram_ready) begin
          pop        = 1'b1;
          state_d    = ST_ISSUE;
          sram_we_d  = 1'b1;
          addr_d     = head_addr;
          wdata_d    = head_data;
          iss_port_d = head_port;
          iss_pri_d  = head_pri;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d     = ST_DONE;
        wr_done_d   = 1'b1;
        done_port_d = iss_port_q;
        done_pri_d  = iss_pri_q;
        wr_count_d  = wr_count_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    transfering_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      sram_we_q     <= 1'b0;
      wr_done_q     <= 1'b0;
      transfering_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      iss_port_q    <= '0;
      iss_pri_q     <= '0;
      done_port_q   <= '0;
      done_pri_q    <= '0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      sram_we_q     <= sram_we_d;
      wr_done_q     <= wr_done_d;
      transfering_q <= transfering_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      iss_port_q    <= iss_port_d;
      iss_pri_q     <= iss_pri_d;
      done_port_q   <= done_port_d;
      done_pri_q    <= done_pri_d;
      wr_count_q    <= wr_count_d;
    end
  end

`ifdef SRAM_WR_PARITY_EN
  logic [DATA_WIDTH/8-1:0] wpar_q, wpar_d;

  // Even parity per byte: the parity bit makes each byte plus its bit even.
  always_comb begin
    wpar_d = wpar_q;
    if (pop) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) wpar_d[i] = ^head_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wpar_q <= '0;
    else      wpar_q <= wpar_d;
  end

  assign sram_wpar = wpar_q;
`endif

  assign sram_we       = sram_we_q;
  assign wr_done       = wr_done_q;
  assign transfering   = transfering_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign done_port     = done_port_q;
  assign done_priority = done_pri_q;
  assign wr_count      = wr_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_wr_ctl.sv
// Bench for sram_wr_ctl: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor.
module tb_sram_wr_ctl;
  import sram_ctl_pkg::*;

  localparam int DW = SRAM_DATA_W;
  localparam int AW = SRAM_ADDR_W;
  localparam int PW = SRAM_DES_W;
  localparam int RW = SRAM_PRI_W;

  logic          clk, rst, request, sram_ready;
  logic [RW-1:0] wr_priority;
  logic [PW-1:0] des_port;
  logic [AW-1:0] address_write;
  logic [DW-1:0] data_write;
  logic          busy, transfering, sram_we, wr_done;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [PW-1:0] done_port;
  logic [RW-1:0] done_priority;
  logic [15:0]   wr_count;
  wr_state_e     dbg_state;
`ifdef SRAM_WR_PARITY_EN
  logic [DW/8-1:0] sram_wpar;
`endif

  sram_wr_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .request       (request),
    .wr_priority   (wr_priority),
    .des_port      (des_port),
    .address_write (address_write),
    .data_write    (data_write),
    .busy          (busy),
    .transfering   (transfering),
    .sram_ready    (sram_ready),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
`ifdef SRAM_WR_PARITY_EN
    .sram_wpar     (sram_wpar),
`endif
    .wr_done       (wr_done),
    .done_port     (done_port),
    .done_priority (done_priority),
    .wr_count      (wr_count),
    .dbg_state     (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    fails++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Scoreboard / reference model
  wr_req_t         exp_q[$];
  logic [PW+RW-1:0] done_q[$];
  logic [15:0]     exp_count = 16'd0;
  int              we_cyc_q[$];
  bit              mon_en = 1'b0;
  logic            prev_we = 1'b0;

  always @(negedge clk) begin : monitor
    wr_req_t          e;
    logic [PW+RW-1:0] d;
    logic [DW/8-1:0]  par;
    if (mon_en && rst) begin
      check("we_done_exclusive", {63'd0, sram_we & wr_done}, 64'd0);
      check("transfering", {63'd0, transfering}, {63'd0, sram_we | wr_done});
      if (prev_we) check("done_follows_we", {63'd0, wr_done}, 64'd1);
      if (sram_we) begin
        we_cyc_q.push_back(cycle);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_we", $sformatf("write to 0x%0h with nothing pending", sram_addr));
        end else begin
          e = exp_q.pop_front();
          check("sram_addr", {52'd0, sram_addr}, {52'd0, e.addr});
          check("sram_wdata", sram_wdata, e.data);
          for (int b = 0; b < DW/8; b++) par[b] = ^e.data[b*8 +: 8];
`ifdef SRAM_WR_PARITY_EN
          check("sram_wpar", {56'd0, sram_wpar}, {56'd0, par});
`endif
          done_q.push_back({e.port, e.pri});
        end
      end
      if (wr_done) begin
        if (done_q.size() == 0) begin
          fail_now("unexpected_done", "wr_done with no issued write");
        end else begin
          d = done_q.pop_front();
          check("done_port", {60'd0, done_port}, {60'd0, d[PW+RW-1:RW]});
          check("done_priority", {61'd0, done_priority}, {61'd0, d[RW-1:0]});
          exp_count = exp_count + 16'd1;
          check("wr_count", {48'd0, wr_count}, {48'd0, exp_count});
        end
      end
      prev_we = sram_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // Driver tasks
  task automatic send(input wr_req_t r);
    int tries = 0;
    bit acc = 1'b0;
    @(negedge clk);
    request       = 1'b1;
    wr_priority   = r.pri;
    des_port      = r.port;
    address_write = r.addr;
    data_write    = r.data;
    while (!acc && tries < 100) begin
      if (!busy) begin
        @(posedge clk);
        exp_q.push_back(r);
        acc = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        tries++;
      end
    end
    #1 request = 1'b0;
    if (!acc) fail_now("send_timeout", "request never accepted");
  endtask

  function automatic wr_req_t rand_req();
    wr_req_t r;
    r.pri  = RW'($urandom_range(0, (1 << RW) - 1));
    r.port = PW'($urandom_range(0, (1 << PW) - 1));
    r.addr = AW'($urandom_range(0, (1 << AW) - 1));
    r.data = {$urandom, $urandom};
    return r;
  endfunction

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) fail_now("drain_timeout", "writes still outstanding");
    @(negedge clk);
  endtask

  task automatic wait_we(input int limit);
    int n = 0;
    @(negedge clk);
    while (!sram_we && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!sram_we) fail_now("wait_we_timeout", "no sram_we seen");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_transfering"}, {63'd0, transfering}, 64'd0);
    check({tag, "_sram_we"}, {63'd0, sram_we}, 64'd0);
    check({tag, "_sram_addr"}, {52'd0, sram_addr}, 64'd0);
    check({tag, "_sram_wdata"}, sram_wdata, 64'd0);
    check({tag, "_wr_done"}, {63'd0, wr_done}, 64'd0);
    check({tag, "_done_port"}, {60'd0, done_port}, 64'd0);
    check({tag, "_done_priority"}, {61'd0, done_priority}, 64'd0);
    check({tag, "_wr_count"}, {48'd0, wr_count}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, {62'd0, ST_IDLE});
`ifdef SRAM_WR_PARITY_EN
    check({tag, "_sram_wpar"}, {56'd0, sram_wpar}, 64'd0);
`endif
  endtask

  initial begin : watchdog
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1);
  end

  initial begin : main
    wr_req_t r;
    bit rand_done;
    rst = 1'b1; request = 1'b0; sram_ready = 1'b0;
    wr_priority = '0; des_port = '0; address_write = '0; data_write = '0;

    // Reset with garbage on the inputs
    #2;
    rst = 1'b0;
    request = 1'b1; sram_ready = 1'b1;
    r = rand_req();
    wr_priority = r.pri; des_port = r.port; address_write = r.addr; data_write = r.data;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    request = 1'b0; sram_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_reset_busy", {63'd0, busy}, 64'd0);

    // Single write with exact latency
    sram_ready = 1'b1;
    r.pri = 3'd3; r.port = 4'd5; r.addr = 12'h123; r.data = 64'hDEAD_BEEF_0000_0001;
    send(r);
    @(negedge clk);
    check("single_we_edge_n", {63'd0, sram_we}, 64'd0);
    @(negedge clk);
    check("single_we_edge_n1", {63'd0, sram_we}, 64'd1);
    check("single_addr", {52'd0, sram_addr}, 64'h123);
    @(negedge clk);
    check("single_done", {63'd0, wr_done}, 64'd1);
    check("single_done_port", {60'd0, done_port}, 64'd5);
    check("single_done_pri", {61'd0, done_priority}, 64'd3);
    check("single_count", {48'd0, wr_count}, 64'd1);
    drain(20);

    // Back-pressure: busy after the third push, fourth held
    sram_ready = 1'b0;
    send(rand_req());
    send(rand_req());
    check("bp_busy_after_2", {63'd0, busy}, 64'd0);
    send(rand_req());
    check("bp_busy_after_3", {63'd0, busy}, 64'd1);
    repeat (3) @(negedge clk);
    check("bp_no_write_stalled", {63'd0, sram_we}, 64'd0);
    we_cyc_q.delete();
    sram_ready = 1'b1;
    send(rand_req());
    drain(40);
    check("bp_write_count", 64'(we_cyc_q.size()), 64'd4);
    for (int i = 1; i < we_cyc_q.size(); i++)
      check("bp_spacing", 64'(we_cyc_q[i] - we_cyc_q[i-1]), 64'd2);

    // Stall during DONE
    sram_ready = 1'b0;
    repeat (3) send(rand_req());
    @(negedge clk);
    sram_ready = 1'b1;
    wait_we(10);
    @(negedge clk);
    check("stall_in_done", {62'd0, dbg_state}, {62'd0, ST_DONE});
    sram_ready = 1'b0;
    @(negedge clk);
    check("stall_state_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check("stall_transfering", {63'd0, transfering}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("stall_no_we", {63'd0, sram_we}, 64'd0);
    end
    sram_ready = 1'b1;
    drain(40);

    // Counter wrap
    force dut.wr_count_q = 16'hFFFF;
    #1 release dut.wr_count_q;
    exp_count = 16'hFFFF;
    check("wrap_preload", {48'd0, wr_count}, 64'hFFFF);
    send(rand_req());
    drain(20);
    check("wrap_count", {48'd0, wr_count}, 64'd0);

    // Byte parity pattern
    r.pri = 3'd1; r.port = 4'd2; r.addr = 12'h001; r.data = 64'h1;
    send(r);
    drain(20);

    // Random traffic with random SRAM availability
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(rand_req());
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          sram_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    sram_ready = 1'b1;
    drain(100);

    // Reset in the middle of a write with two entries queued behind it
    sram_ready = 1'b0;
    repeat (3) send(rand_req());
    @(negedge clk);
    sram_ready = 1'b1;
    wait_we(10);
    mon_en = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    exp_count = 16'd0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midreset_no_we", {63'd0, sram_we}, 64'd0);
      check("midreset_no_done", {63'd0, wr_done}, 64'd0);
    end
    check("midreset_busy", {63'd0, busy}, 64'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
